// File: rtl/camera_frame_sequencer.sv
// camera_frame_sequencer: issues period-spaced frame triggers to the camera
// pixel-stream generator, counts completed frames in burst or continuous
// mode, and flags late frames (overrun) and a stuck generator (timeout).
// Optional build macro: FRAME_VALID_CHECK_EN adds gen_frame_valid /
// no_frame_err. A done edge with no frame-valid activity since the last
// trigger is then flagged and not counted.
module camera_frame_sequencer #(
    parameter int COUNT_W        = 16,
    parameter int PERIOD_W       = 24,
    parameter int TRIG_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 4194304
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic                continuous,
    input  logic [COUNT_W-1:0]  frame_count_cfg,
    input  logic [PERIOD_W-1:0] frame_period_cfg,
    input  logic                gen_done,
`ifdef FRAME_VALID_CHECK_EN
    input  logic                gen_frame_valid,
    output logic                no_frame_err,
`endif
    output logic                gen_en,
    output logic                busy,
    output logic [COUNT_W-1:0]  frames_done,
    output logic                overrun_err,
    output logic                timeout_err,
    output logic                seq_done
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int TW_W = $clog2(TRIG_WIDTH) + 1;
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(TRIG_WIDTH + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_TRIGGER, S_WAIT_DONE, S_WAIT_PERIOD, S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] period_eff_q;
    logic [COUNT_W-1:0]  count_q;
    logic                cont_q;
    logic [PERIOD_W-1:0] period_cnt_q;
    logic [TO_W-1:0]     timeout_cnt_q;
    logic [TW_W-1:0]     trig_cnt_q;
    logic                stop_pend_q;
    logic                gen_done_q;
    logic [COUNT_W-1:0]  frames_q;
    logic                overrun_q, timeout_q;

    logic                accept, enter_trig, done_rise;
    logic                period_hit, period_late, timeout_hit, frame_ok;
    logic [COUNT_W-1:0]  frames_inc, frames_new;

    assign done_rise   = gen_done & ~gen_done_q;
    assign period_hit  = (period_cnt_q == period_eff_q - PERIOD_W'(1));
    assign period_late = (period_cnt_q >= period_eff_q - PERIOD_W'(1));
    assign timeout_hit = (timeout_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign frames_inc  = (frames_q == '1) ? frames_q : frames_q + COUNT_W'(1);
    assign frames_new  = frame_ok ? frames_inc : frames_q;
    assign enter_trig  = (state_d == S_TRIGGER) && (state_q != S_TRIGGER);

`ifdef FRAME_VALID_CHECK_EN
    logic fv_seen_q, no_frame_q;
    assign frame_ok     = fv_seen_q | gen_frame_valid;
    assign no_frame_err = no_frame_q;

    // Track frame-valid activity since the last trigger; sticky missing-frame flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fv_seen_q  <= 1'b0;
            no_frame_q <= 1'b0;
        end else begin
            if (enter_trig)           fv_seen_q <= 1'b0;
            else if (gen_frame_valid) fv_seen_q <= 1'b1;
            if (accept)
                no_frame_q <= 1'b0;
            else if (state_q == S_WAIT_DONE && done_rise && !frame_ok)
                no_frame_q <= 1'b1;
        end
    end
`else
    assign frame_ok = 1'b1;
`endif

    // Moore outputs decoded from state so reset drops them asynchronously
    assign gen_en      = (state_q == S_TRIGGER);
    assign busy        = (state_q == S_TRIGGER) || (state_q == S_WAIT_DONE) ||
                         (state_q == S_WAIT_PERIOD);
    assign seq_done    = (state_q == S_FINISH);
    assign frames_done = frames_q;
    assign overrun_err = overrun_q;
    assign timeout_err = timeout_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    accept  = 1'b1;
                    state_d = (!continuous && frame_count_cfg == '0) ? S_FINISH : S_TRIGGER;
                end
            end
            S_TRIGGER: begin
                if (trig_cnt_q == TW_W'(TRIG_WIDTH - 1)) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done_rise) begin
                    if (stop || stop_pend_q || (!cont_q && frames_new == count_q))
                        state_d = S_FINISH;
                    else if (period_late)
                        state_d = S_TRIGGER;  // late frame: retrigger at once
                    else
                        state_d = S_WAIT_PERIOD;
                end else if (timeout_hit) begin
                    state_d = S_FINISH;
                end
            end
            S_WAIT_PERIOD: begin
                if (stop || stop_pend_q) state_d = S_FINISH;
                else if (period_hit)     state_d = S_TRIGGER;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Config latch, done-edge history and pending-stop capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_eff_q <= '0;
            count_q      <= '0;
            cont_q       <= 1'b0;
            gen_done_q   <= 1'b0;
            stop_pend_q  <= 1'b0;
        end else begin
            gen_done_q <= gen_done;
            if (accept) begin
                period_eff_q <= (frame_period_cfg < MIN_PERIOD) ? MIN_PERIOD : frame_period_cfg;
                count_q      <= frame_count_cfg;
                cont_q       <= continuous;
            end
            if (accept || state_q == S_FINISH)
                stop_pend_q <= 1'b0;
            else if (stop && (state_q == S_TRIGGER || state_q == S_WAIT_DONE))
                stop_pend_q <= 1'b1;
        end
    end

    // Trigger width, frame period and timeout counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_cnt_q    <= '0;
            period_cnt_q  <= '0;
            timeout_cnt_q <= '0;
        end else begin
            trig_cnt_q <= (state_q == S_TRIGGER && state_d == S_TRIGGER) ?
                          trig_cnt_q + TW_W'(1) : '0;
            if (enter_trig)
                period_cnt_q <= '0;
            else if (busy && period_cnt_q != '1)
                period_cnt_q <= period_cnt_q + PERIOD_W'(1);
            if (state_q == S_TRIGGER)
                timeout_cnt_q <= '0;
            else if (state_q == S_WAIT_DONE)
                timeout_cnt_q <= timeout_cnt_q + TO_W'(1);
        end
    end

    // Frame count and sticky error flags, cleared on an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_q  <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else if (accept) begin
            frames_q  <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else if (state_q == S_WAIT_DONE) begin
            if (period_hit)                 overrun_q <= 1'b1;
            if (done_rise)                  frames_q  <= frames_new;
            else if (timeout_hit)           timeout_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_camera_frame_sequencer.sv
// Directed bench for camera_frame_sequencer (TIMEOUT_CYCLES shortened to 64).
module tb_camera_frame_sequencer;

    localparam int COUNT_W        = 16;
    localparam int PERIOD_W       = 24;
    localparam int TRIG_WIDTH     = 2;
    localparam int TIMEOUT_CYCLES = 64;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0, stop = 1'b0, continuous = 1'b0, gen_done = 1'b0;
    logic [COUNT_W-1:0]  frame_count_cfg = '0;
    logic [PERIOD_W-1:0] frame_period_cfg = '0;
    logic                gen_en, busy, overrun_err, timeout_err, seq_done;
    logic [COUNT_W-1:0]  frames_done;
`ifdef FRAME_VALID_CHECK_EN
    logic                gen_frame_valid = 1'b1;
    logic                no_frame_err;
`endif

    int tests = 0, failed = 0;
    int cyc = 0, rises = 0, sd_hi = 0;
    logic en_prev = 1'b0;

    camera_frame_sequencer #(
        .COUNT_W(COUNT_W), .PERIOD_W(PERIOD_W),
        .TRIG_WIDTH(TRIG_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
        .frame_count_cfg(frame_count_cfg), .frame_period_cfg(frame_period_cfg),
        .gen_done(gen_done),
`ifdef FRAME_VALID_CHECK_EN
        .gen_frame_valid(gen_frame_valid), .no_frame_err(no_frame_err),
`endif
        .gen_en(gen_en), .busy(busy), .frames_done(frames_done),
        .overrun_err(overrun_err), .timeout_err(timeout_err), .seq_done(seq_done)
    );

    always #5 clk = ~clk;

    // Cycle counter for measuring trigger spacing
    always @(posedge clk) cyc <= cyc + 1;

    // Count gen_en rising edges and seq_done high cycles
    always @(negedge clk) begin
        en_prev <= gen_en;
        if (gen_en && !en_prev) rises <= rises + 1;
        if (seq_done) sd_hi <= sd_hi + 1;
    end

    // Hard time limit
    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_en(input logic v, input int budget, input string tag);
        int n = 0;
        while (gen_en !== v && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 32'(gen_en), 32'(v));
    endtask

    task automatic go(input int cnt, input int per, input logic cont);
        frame_count_cfg  = COUNT_W'(cnt);
        frame_period_cfg = PERIOD_W'(per);
        continuous       = cont;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        int rt[4];
        int rs, sd0;

        // reset state
        #12;
        check("rst_gen_en", 32'(gen_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frames", 32'(frames_done), 0);
        check("rst_overrun", 32'(overrun_err), 0);
        check("rst_timeout", 32'(timeout_err), 0);
        check("rst_seq_done", 32'(seq_done), 0);
        rst_n = 1'b1;
        tick(2);

        // 1: burst of 3, period 100, done 20 cycles after trigger falls
        sd0 = sd_hi;
        go(3, 100, 1'b0);
        check("t1_latency", 32'(gen_en), 1);
        check("t1_busy", 32'(busy), 1);
        for (int f = 0; f < 3; f++) begin
            if (f > 0) wait_en(1'b1, 150, "t1_rise");
            rt[f] = cyc;
            wait_en(1'b0, 10, "t1_fall");
            tick(20);
            gen_done = 1'b1;
            tick(1);
            check("t1_frames", 32'(frames_done), f + 1);
            check("t1_seq_done", 32'(seq_done), (f == 2) ? 1 : 0);
            gen_done = 1'b0;
        end
        check("t1_spacing_a", rt[1] - rt[0], 100);
        check("t1_spacing_b", rt[2] - rt[1], 100);
        tick(1);
        check("t1_seq_done_drop", 32'(seq_done), 0);
        check("t1_busy_end", 32'(busy), 0);
        check("t1_overrun", 32'(overrun_err), 0);
        check("t1_timeout", 32'(timeout_err), 0);
        check("t1_sd_width", sd_hi - sd0, 1);
        tick(2);

        // 2: overrun, period 10, done 30 cycles after trigger
        go(2, 10, 1'b0);
        tick(29);
        check("t2_no_retrig", 32'(gen_en), 0);
        tick(1);
        gen_done = 1'b1;
        tick(1);
        check("t2_immediate_trig", 32'(gen_en), 1);
        check("t2_overrun", 32'(overrun_err), 1);
        check("t2_frames1", 32'(frames_done), 1);
        gen_done = 1'b0;
        tick(5);
        gen_done = 1'b1;
        tick(1);
        check("t2_seq_done", 32'(seq_done), 1);
        check("t2_frames2", 32'(frames_done), 2);
        gen_done = 1'b0;
        tick(3);

        // 3: timeout after 64 WAIT_DONE cycles
        go(1, 1000, 1'b0);
        tick(65);
        check("t3_not_yet", 32'(timeout_err), 0);
        check("t3_busy_before", 32'(busy), 1);
        tick(1);
        check("t3_timeout", 32'(timeout_err), 1);
        check("t3_seq_done", 32'(seq_done), 1);
        check("t3_frames", 32'(frames_done), 0);
        check("t3_overrun", 32'(overrun_err), 0);
        tick(3);

        // 4: continuous, period 50, stop pulse inside frame 4's WAIT_DONE
        go(0, 50, 1'b1);
        for (int f = 0; f < 4; f++) begin
            if (f > 0) wait_en(1'b1, 100, "t4_rise");
            rt[f] = cyc;
            tick(5);
            if (f == 3) begin
                stop = 1'b1;
                tick(1);
                stop = 1'b0;
                tick(4);
            end else begin
                tick(5);
            end
            gen_done = 1'b1;
            tick(1);
            check("t4_frames", 32'(frames_done), f + 1);
            check("t4_seq_done", 32'(seq_done), (f == 3) ? 1 : 0);
            gen_done = 1'b0;
        end
        check("t4_spacing", rt[3] - rt[2], 50);
        rs = rises;
        tick(120);
        check("t4_no_fifth", rises - rs, 0);
        check("t4_busy_end", 32'(busy), 0);
        continuous = 1'b0;

        // 5a: count 0 finishes without a trigger
        rs = rises;
        go(0, 10, 1'b0);
        check("t5a_seq_done", 32'(seq_done), 1);
        check("t5a_gen_en", 32'(gen_en), 0);
        tick(1);
        check("t5a_seq_drop", 32'(seq_done), 0);
        tick(1);
        check("t5a_no_rise", rises - rs, 0);

        // 5b: start+stop together ignored; start while busy ignored
        start = 1'b1; stop = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        check("t5b_start_stop", 32'(busy), 0);
        tick(1);
        go(1, 20, 1'b0);
        tick(1);
        frame_count_cfg = 16'd5; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        gen_done = 1'b1;
        tick(1);
        check("t5b_seq_done", 32'(seq_done), 1);
        check("t5b_frames", 32'(frames_done), 1);
        gen_done = 1'b0;
        tick(2);

        // 5c: period 1 clamps to TRIG_WIDTH+2 = 4
        go(2, 1, 1'b0);
        tick(2);
        gen_done = 1'b1;
        tick(1);
        check("t5c_gap", 32'(gen_en), 0);
        gen_done = 1'b0;
        tick(1);
        check("t5c_period4", 32'(gen_en), 1);
        check("t5c_overrun", 32'(overrun_err), 0);
        tick(2);
        gen_done = 1'b1;
        tick(1);
        check("t5c_seq_done", 32'(seq_done), 1);
        check("t5c_frames", 32'(frames_done), 2);
        gen_done = 1'b0;
        tick(2);

`ifdef FRAME_VALID_CHECK_EN
        // 6: done without frame-valid is flagged and not counted
        gen_frame_valid = 1'b0;
        go(1, 30, 1'b0);
        tick(5);
        gen_done = 1'b1;
        tick(1);
        check("t6_no_frame", 32'(no_frame_err), 1);
        check("t6_not_counted", 32'(frames_done), 0);
        check("t6_continues", 32'(seq_done), 0);
        gen_done = 1'b0;
        wait_en(1'b1, 60, "t6_rise");
        tick(3);
        gen_frame_valid = 1'b1;
        tick(1);
        gen_frame_valid = 1'b0;
        tick(2);
        gen_done = 1'b1;
        tick(1);
        check("t6_counted", 32'(frames_done), 1);
        check("t6_seq_done", 32'(seq_done), 1);
        check("t6_sticky", 32'(no_frame_err), 1);
        gen_done = 1'b0;
        gen_frame_valid = 1'b1;
        tick(2);
`endif

        // 5d: async reset during a trigger pulse of frame 2
        go(2, 20, 1'b0);
        tick(4);
        gen_done = 1'b1;
        tick(1);
        gen_done = 1'b0;
        wait_en(1'b1, 40, "t5d_rise");
        check("t5d_frames_pre", 32'(frames_done), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5d_gen_en", 32'(gen_en), 0);
        check("t5d_busy", 32'(busy), 0);
        check("t5d_frames", 32'(frames_done), 0);
        check("t5d_seq_done", 32'(seq_done), 0);
        rst_n = 1'b1;
        tick(3);
        check("t5d_idle", 32'(gen_en), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
